// File: rtl/sad_scheduler.sv
// sad_scheduler: buffers incoming pixel columns in a small FIFO and feeds them
// one at a time to the SAD disparity engine, tracking each to completion.
// Flags the end of a frame and latches a sticky fault if the engine hangs.
module sad_scheduler #(
  parameter int KERNEL_WIDTH = 3,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT      = 64,
  parameter int LAST_H       = 319,
  parameter int LAST_V       = 239
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           col_valid_in,
  output logic                           col_ready_out,
  input  logic [KERNEL_WIDTH*8-1:0]      left_col_in,
  input  logic [KERNEL_WIDTH*8-1:0]      right_col_in,
  input  logic [10:0]                    hcount_in,
  input  logic [9:0]                     vcount_in,
  input  logic                           sad_busy_in,
  input  logic                           sad_done_in,
  output logic                           sad_valid_out,
  output logic [KERNEL_WIDTH*8-1:0]      sad_left_out,
  output logic [KERNEL_WIDTH*8-1:0]      sad_right_out,
  output logic [10:0]                    sad_hcount_out,
  output logic [9:0]                     sad_vcount_out,
  output logic                           in_flight_out,
  output logic                           frame_done_out,
  output logic                           timeout_err_out,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_out
);

  localparam int PW = KERNEL_WIDTH * 8;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int EW = 2 * PW + 21;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WDOG_LAST  = CW'(TIMEOUT - 1);
  localparam logic [10:0]   H_LAST     = 11'(LAST_H);
  localparam logic [9:0]    V_LAST     = 10'(LAST_V);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_COMPLETE  = 3'd4
  } state_t;

  // Watchdog increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == {CW{1'b1}}) begin
      r = v;
    end else begin
      r = v + CW'(1);
    end
    return r;
  endfunction

  // ---------------- column FIFO ----------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_s, empty_s, push_s, pop_s;
  logic [EW-1:0] head_s;

  // ---------------- FSM / output registers ----------------
  state_t        state_q, state_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          fd_q, fd_d;
  logic          inflight_q, inflight_d;
  logic          load_s;
  logic [PW-1:0] left_q, right_q;
  logic [10:0]   hcount_q;
  logic [9:0]    vcount_q;

  assign full_s  = (level_q == LEVEL_FULL);
  assign empty_s = (level_q == '0);
  assign push_s  = col_valid_in & ~full_s;
  assign pop_s   = (state_q == S_ISSUE);
  assign head_s  = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy next-state; pointers wrap naturally at a power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {left_col_in, right_col_in, hcount_in, vcount_in};
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Issue/track sequencing with watchdog; all outputs derive from the next state.
  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    load_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s && !sad_busy_in && !sad_done_in) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        load_s  = 1'b1;
        valid_d = 1'b1;
        wdog_d  = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        wdog_d = sat_inc(wdog_q);
        if (sad_done_in) begin
          state_d = S_COMPLETE;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (sad_busy_in) begin
          state_d = S_WAIT_DONE;
        end else begin
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        wdog_d = sat_inc(wdog_q);
        if (sad_done_in) begin
          state_d = S_COMPLETE;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_COMPLETE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    inflight_d = (state_d == S_WAIT_BUSY) || (state_d == S_WAIT_DONE) ||
                 (state_d == S_COMPLETE);
    fd_d       = (state_d == S_COMPLETE) && (hcount_q == H_LAST) && (vcount_q == V_LAST);
  end

  // FSM state, watchdog and status strobes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      fd_q       <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      fd_q       <= fd_d;
      inflight_q <= inflight_d;
    end
  end

  // Issued column registers; hold their value until the next issue.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      left_q   <= '0;
      right_q  <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else if (load_s) begin
      left_q   <= head_s[EW-1 -: PW];
      right_q  <= head_s[EW-PW-1 -: PW];
      hcount_q <= head_s[20:10];
      vcount_q <= head_s[9:0];
    end else begin
      left_q   <= left_q;
      right_q  <= right_q;
      hcount_q <= hcount_q;
      vcount_q <= vcount_q;
    end
  end

  assign col_ready_out   = ~full_s;
  assign fifo_level_out  = level_q;
  assign sad_valid_out   = valid_q;
  assign sad_left_out    = left_q;
  assign sad_right_out   = right_q;
  assign sad_hcount_out  = hcount_q;
  assign sad_vcount_out  = vcount_q;
  assign in_flight_out   = inflight_q;
  assign frame_done_out  = fd_q;
  assign timeout_err_out = err_q;

endmodule
